mem_arbiter: RTL and testbench

- Upstream master for the word-addressed latency memory model.
- Merges two pipeline clients onto the memory's single-transaction req/busy/valid interface: instruction fetch (read-only) and load/store (read/write).
- Owns the one-cycle req pulse.
- Holds address, write-enable and write data stable for the whole transaction.
- Routes the completion pulse and read data back to the owning client.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_grant.sv | 40 ++++
 rtl/mem_arbiter.sv | 109 ++++++++++
 tb/tb_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types for the two-client memory arbiter: owner and
//                state encodings used by mem_arbiter and mem_arb_grant.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    // Which client owns (or is granted) the memory transaction.
    typedef enum logic [0:0] {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    // Arbiter sequencing: IDLE looks for work, WAIT holds the bus until completion.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage : mem_arb_pkg

`default_nettype wire

// File: rtl/mem_arb_grant.sv
// ============================================================================
//  Module      : mem_arb_grant
//  Description : Combinational grant between fetch and load/store clients.
//                Configuration macro ARB_RR_EN: when defined, simultaneous
//                requests alternate away from last_owner; when undefined,
//                load/store has fixed priority over fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   ls_req,
    input  owner_e last_owner,
    output logic   grant_valid,
    output owner_e grant_owner
);

`ifndef ARB_RR_EN
    // Fixed priority ignores history; keep the input visibly consumed.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    // Pick the winning client; a lone requester always wins.
    always_comb begin
        grant_valid = if_req | ls_req;
        grant_owner = ls_req ? OWN_LS : OWN_IF;
`ifdef ARB_RR_EN
        if (if_req && ls_req) begin
            grant_owner = (last_owner == OWN_LS) ? OWN_IF : OWN_LS;
        end
`endif
    end

endmodule : mem_arb_grant

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module      : mem_arbiter
//  Description : Merges instruction fetch (read-only) and load/store clients
//                onto a single-transaction req/busy/valid memory port. Issues
//                a one-cycle req pulse, holds addr/we/wdata for the whole
//                transaction and steers completion back to the owner.
//                Configuration macro ARB_RR_EN (see mem_arb_grant) selects
//                round-robin instead of fixed ls-over-if priority.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic [DW-1:0] ls_rdata,
    output logic          ls_done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_busy,
    input  logic          mem_valid
);

    state_e state;
    owner_e owner;
    owner_e last_owner;
    owner_e grant_owner;
    logic   grant_valid;

    mem_arb_grant u_grant (
        .if_req      (if_req),
        .ls_req      (ls_req),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // Issue one transaction at a time and hold the bus until the memory completes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            owner      <= OWN_LS;
            last_owner <= OWN_LS;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid && !mem_busy) begin
                        owner   <= grant_owner;
                        mem_req <= 1'b1;
                        state   <= ST_WAIT;
                        if (grant_owner == OWN_LS) begin
                            mem_addr  <= ls_addr;
                            mem_we    <= ls_we;
                            mem_wdata <= ls_wdata;
                        end else begin
                            // Fetch is read-only; never leave stale store data on the bus.
                            mem_addr  <= if_addr;
                            mem_we    <= 1'b0;
                            mem_wdata <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    // Clearing every WAIT cycle makes the req pulse exactly one cycle wide.
                    mem_req <= 1'b0;
                    if (mem_valid) begin
                        state      <= ST_IDLE;
                        last_owner <= owner;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Steer completion to the owning client; data is shared and qualified by done.
    always_comb begin
        if_done  = (state == ST_WAIT) && mem_valid && (owner == OWN_IF);
        ls_done  = (state == ST_WAIT) && mem_valid && (owner == OWN_LS);
        if_rdata = mem_rdata;
        ls_rdata = mem_rdata;
    end

endmodule : mem_arbiter

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter with a latency-3
//                word-addressed memory model and an expected-completion queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int LATENCY = 3;
    localparam bit OWN_IF_B = 1'b0;
    localparam bit OWN_LS_B = 1'b1;

    logic          clk;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic [DW-1:0] ls_rdata;
    logic          ls_done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_busy;
    logic          mem_valid;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_rdata  (ls_rdata),
        .ls_done   (ls_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_busy  (mem_busy),
        .mem_valid (mem_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Memory model: accepts req at an edge, asserts valid LATENCY-1 edges
    // later (done is seen LATENCY+1 edges after the arbiter issues).
    // Writes take effect at completion using the bus values at that time.
    // ------------------------------------------------------------------
    logic [31:0] mem_arr [0:63];
    int          mcnt;

    initial begin
        for (int i = 0; i < 64; i++) mem_arr[i] = '0;
        mem_arr[4] = 32'hDEADBEEF;
        mem_busy   = 1'b0;
        mem_valid  = 1'b0;
        mem_rdata  = '0;
        mcnt       = 0;
    end

    always @(posedge clk) begin
        if (mem_valid) begin
            mem_valid <= 1'b0;
            mem_busy  <= 1'b0;
        end else if (mem_busy) begin
            if (mcnt == 0) begin
                mem_valid <= 1'b1;
                if (mem_we) mem_arr[mem_addr[7:2]] <= mem_wdata;
                else        mem_rdata <= mem_arr[mem_addr[7:2]];
            end else begin
                mcnt <= mcnt - 1;
            end
        end else if (mem_req) begin
            mem_busy <= 1'b1;
            mcnt     <= LATENCY - 2;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard of expected completions, in order.
    // ------------------------------------------------------------------
    typedef struct {
        bit          own;
        logic [31:0] data;
        bit          chk_data;
    } exp_t;

    exp_t exp_q[$];
    bit   last_own;    // reference copy of the arbiter's history
    logic prev_req;

    task automatic push_exp(input bit own, input logic [31:0] data, input bit chk_data);
        exp_t e;
        e.own = own; e.data = data; e.chk_data = chk_data;
        exp_q.push_back(e);
        last_own = own;
    endtask

    // Winner when both clients request, given the reference history.
    function automatic bit both_winner(input bit last);
`ifdef ARB_RR_EN
        return (last == OWN_LS_B) ? OWN_IF_B : OWN_LS_B;
`else
        return OWN_LS_B;
`endif
    endfunction

    task automatic pop_cmp(input bit own, input logic [31:0] data);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq("done_owner", {31'd0, own}, {31'd0, e.own});
            if (e.chk_data) check_eq("rdata", data, e.data);
        end
    endtask

    // Monitor: completions and req pulse width, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (if_done && ls_done) check_eq("dual_done", 32'd1, 32'd0);
            else if (if_done)       pop_cmp(OWN_IF_B, if_rdata);
            else if (ls_done)       pop_cmp(OWN_LS_B, ls_rdata);
            if (mem_req && prev_req) check_eq("req_pulse_width", 32'd2, 32'd1);
            prev_req <= mem_req;
        end else begin
            prev_req <= 1'b0;
        end
    end

    // Waits for the selected done; returns negedge count or 0 on timeout.
    task automatic wait_done(input bit is_ls, output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if ((is_ls && ls_done) || (!is_ls && if_done)) begin
                n = i;
                break;
            end
        end
        if (n == 0) check_eq(is_ls ? "ls_done_timeout" : "if_done_timeout", 32'd0, 32'd1);
    endtask

    int n;
    int cnt;

    initial begin
        rst_n    = 1'b0;
        if_req   = 1'b0; if_addr = '0;
        ls_req   = 1'b0; ls_we   = 1'b0; ls_addr = '0; ls_wdata = '0;
        last_own = OWN_LS_B;
        prev_req = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_mem_req",   {31'd0, mem_req}, 32'd0);
        check_eq("rst_mem_we",    {31'd0, mem_we},  32'd0);
        check_eq("rst_mem_addr",  mem_addr,  32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        check_eq("rst_dones",     {30'd0, if_done, ls_done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fetch read
        if_req = 1'b1; if_addr = 32'h10;
        push_exp(OWN_IF_B, 32'hDEADBEEF, 1'b1);
        @(negedge clk);
        check_eq("f_req",  {31'd0, mem_req}, 32'd1);
        check_eq("f_addr", mem_addr, 32'h10);
        check_eq("f_we",   {31'd0, mem_we}, 32'd0);
        wait_done(1'b0, n);
        check_eq("f_latency", n, 32'd3);   // 4th negedge after drive, 3 after the first
        if_req = 1'b0;
        @(negedge clk);

        // Store then load to 0x20
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h20; ls_wdata = 32'h12345678;
        push_exp(OWN_LS_B, '0, 1'b0);
        wait_done(1'b1, n);
        check_eq("st_latency", n, 32'd4);
        ls_we = 1'b0;
        push_exp(OWN_LS_B, 32'h12345678, 1'b1);
        wait_done(1'b1, n);
        ls_req = 1'b0;
        @(negedge clk);

        // Simultaneous requests, each drops on its own done
        if_req = 1'b1; if_addr = 32'h10;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h20;
        if (both_winner(last_own) == OWN_LS_B) begin
            push_exp(OWN_LS_B, 32'h12345678, 1'b1);
            push_exp(OWN_IF_B, 32'hDEADBEEF, 1'b1);
        end else begin
            push_exp(OWN_IF_B, 32'hDEADBEEF, 1'b1);
            push_exp(OWN_LS_B, 32'h12345678, 1'b1);
        end
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ls_done) begin ls_req = 1'b0; cnt++; end
            if (if_done) begin if_req = 1'b0; cnt++; end
        end
        check_eq("sim_completions", cnt, 32'd2);
        if_req = 1'b0; ls_req = 1'b0;
        @(negedge clk);

        // Both held continuously for four transactions
        if_req = 1'b1; ls_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (both_winner(last_own) == OWN_LS_B) push_exp(OWN_LS_B, 32'h12345678, 1'b1);
            else                                   push_exp(OWN_IF_B, 32'hDEADBEEF, 1'b1);
        end
        cnt = 0;
        for (int i = 0; i < 40 && cnt < 4; i++) begin
            @(negedge clk);
            if (ls_done || if_done) cnt++;
        end
        if_req = 1'b0; ls_req = 1'b0;
        check_eq("held_completions", cnt, 32'd4);
        @(negedge clk);

        // Client changes address/data mid-WAIT; bus must stay put
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h40; ls_wdata = 32'hA5A50001;
        push_exp(OWN_LS_B, '0, 1'b0);
        @(negedge clk);
        check_eq("mw_req",  {31'd0, mem_req}, 32'd1);
        ls_addr = 32'h44; ls_wdata = 32'hFFFF0000; ls_we = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            check_eq("mw_addr",  mem_addr,  32'h40);
            check_eq("mw_wdata", mem_wdata, 32'hA5A50001);
            check_eq("mw_we",    {31'd0, mem_we}, 32'd1);
            if (ls_done) begin n = 1; break; end
            @(negedge clk);
        end
        check_eq("mw_done_seen", n, 32'd1);
        ls_req = 1'b0;
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h40;
        push_exp(OWN_LS_B, 32'hA5A50001, 1'b1);
        wait_done(1'b1, n);
        ls_addr = 32'h44;
        push_exp(OWN_LS_B, 32'h00000000, 1'b1);
        wait_done(1'b1, n);
        ls_req = 1'b0;
        @(negedge clk);

        // Reset during WAIT: abandon, ignore the stray valid, then recover
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        check_eq("rw_req", {31'd0, mem_req}, 32'd1);
        rst_n = 1'b0;
        if_req = 1'b0;
        #1;
        check_eq("rw_req_rst",  {31'd0, mem_req}, 32'd0);
        check_eq("rw_addr_rst", mem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (if_done || ls_done) cnt++;
        end
        check_eq("rw_no_done", cnt, 32'd0);
        last_own = OWN_LS_B;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h20;
        push_exp(OWN_LS_B, 32'h12345678, 1'b1);
        wait_done(1'b1, n);
        check_eq("rw_recover_latency", n, 32'd4);
        ls_req = 1'b0;

        repeat (4) @(negedge clk);
        check_eq("sb_leftover", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mem_arbiter

`default_nettype wire
